// File: rtl/instruction_store.sv
// rtl/instruction_store.sv - loadable instruction memory with run control for the Hack CPU
//
// Holds the CPU in reset while a program is streamed in as bytes, then
// releases it and serves registered instruction fetches.
//
// Parameters:
//   DATA_W       instruction width in bits (multiple of 8)
//   ADDR_W       fetch/write address width
//   DEPTH        stored words, DEPTH <= 2**ADDR_W
// Ports:
//   clk          rising-edge clock
//   reset        asynchronous active-low reset
//   load_start   one-cycle request to begin a load session
//   load_len     words to load, sampled with an accepted load_start
//   rx_data      program byte, first byte of a word is its MSB
//   rx_valid     rx_data valid
//   rx_ready     byte accepted when rx_valid && rx_ready
//   pc           CPU fetch address
//   inst         registered instruction (0 outside RUN)
//   cpu_reset    active-high reset to the CPU
//   busy         high while loading or flushing
//   done         one-cycle pulse in the first RUN cycle after a load
//   error        sticky, set by a rejected load_start
//   words_loaded words written in the current or most recent session
module instruction_store #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 15,
    parameter int DEPTH  = 32768
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load_start,
    input  logic [ADDR_W:0]   load_len,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic              rx_ready,
    input  logic [ADDR_W-1:0] pc,
    output logic [DATA_W-1:0] inst,
    output logic              cpu_reset,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [ADDR_W:0]   words_loaded
);

    localparam int BYTES = DATA_W / 8;
    localparam int BC_W  = (BYTES > 1) ? $clog2(BYTES) : 1;
    localparam int MA_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [BC_W-1:0] LAST_BYTE = BC_W'(BYTES - 1);
    localparam logic [ADDR_W:0] DEPTH_L   = (ADDR_W + 1)'(DEPTH);

    typedef enum logic [1:0] {
        S_HOLD,
        S_LOAD,
        S_FLUSH,
        S_RUN
    } state_t;

    state_t state;
    state_t state_next;

    logic [BC_W-1:0]   byte_cnt;
    logic [DATA_W-1:0] shift;
    logic [ADDR_W:0]   len_q;
    logic [DATA_W-1:0] mem [DEPTH];

    logic              len_ok;
    logic              can_start;
    logic              start_ok;
    logic              start_bad;
    logic              accept;
    logic              last_byte;
    logic              word_wr;
    logic [DATA_W-1:0] word_next;
    logic [ADDR_W:0]   wl_inc;
    logic              fetch_ok;
    logic [MA_W-1:0]   wr_addr;
    logic [MA_W-1:0]   rd_addr;

    assign len_ok    = (load_len != '0) && (load_len <= DEPTH_L);
    // load_start is only honoured from HOLD and RUN; LOAD and FLUSH ignore it.
    assign can_start = (state == S_HOLD) || (state == S_RUN);
    assign start_ok  = load_start && can_start && len_ok;
    assign start_bad = load_start && can_start && !len_ok;

    assign accept    = (state == S_LOAD) && rx_valid;
    assign last_byte = (byte_cnt == LAST_BYTE);
    assign word_wr   = accept && last_byte;
    // Earlier bytes sit in the low end of shift; shifting up keeps byte 0 as MSB.
    assign word_next = (shift << 8) | DATA_W'(rx_data);
    assign wl_inc    = words_loaded + (ADDR_W + 1)'(1);

    assign fetch_ok  = ({1'b0, pc} < DEPTH_L);
    assign wr_addr   = words_loaded[MA_W-1:0];
    assign rd_addr   = pc[MA_W-1:0];

    assign rx_ready  = (state == S_LOAD);
    assign cpu_reset = (state != S_RUN);
    assign busy      = (state == S_LOAD) || (state == S_FLUSH);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= S_HOLD;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            S_HOLD: begin
                if (start_ok) begin
                    state_next = S_LOAD;
                end
            end
            S_LOAD: begin
                if (word_wr && (wl_inc == len_q)) begin
                    state_next = S_FLUSH;
                end
            end
            S_FLUSH: begin
                state_next = S_RUN;
            end
            S_RUN: begin
                if (start_ok) begin
                    state_next = S_LOAD;
                end
            end
            default: begin
                state_next = S_HOLD;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            byte_cnt     <= '0;
            shift        <= '0;
            len_q        <= '0;
            words_loaded <= '0;
            error        <= 1'b0;
            done         <= 1'b0;
            inst         <= '0;
        end else begin
            done <= (state == S_FLUSH);

            if (start_ok) begin
                error        <= 1'b0;
                words_loaded <= '0;
                len_q        <= load_len;
                byte_cnt     <= '0;
                shift        <= '0;
            end else if (start_bad) begin
                error <= 1'b1;
            end

            if (accept) begin
                if (last_byte) begin
                    byte_cnt     <= '0;
                    shift        <= '0;
                    words_loaded <= wl_inc;
                end else begin
                    byte_cnt <= byte_cnt + BC_W'(1);
                    shift    <= word_next;
                end
            end

            // Only fetch when staying in RUN so a reload sees inst=0 from its first LOAD cycle.
            if ((state == S_RUN) && (state_next == S_RUN) && fetch_ok) begin
                inst <= mem[rd_addr];
            end else begin
                inst <= '0;
            end
        end
    end

    // Storage has no reset so a program survives a reset pulse.
    always_ff @(posedge clk) begin
        if (word_wr) begin
            mem[wr_addr] <= word_next;
        end
    end

endmodule

// File: tb/tb_instruction_store.sv
// tb/tb_instruction_store.sv - directed self-checking bench for instruction_store
module tb_instruction_store;

    localparam int DATA_W = 16;
    localparam int ADDR_W = 4;
    localparam int DEPTH  = 4;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic              load_start = 1'b0;
    logic [ADDR_W:0]   load_len = '0;
    logic [7:0]        rx_data = '0;
    logic              rx_valid = 1'b0;
    logic              rx_ready;
    logic [ADDR_W-1:0] pc = '0;
    logic [DATA_W-1:0] inst;
    logic              cpu_reset;
    logic              busy;
    logic              done;
    logic              error;
    logic [ADDR_W:0]   words_loaded;

    int n_cmp = 0;
    int n_bad = 0;
    logic [7:0] stim[$];

    instruction_store #(
        .DATA_W(DATA_W),
        .ADDR_W(ADDR_W),
        .DEPTH (DEPTH)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .load_start  (load_start),
        .load_len    (load_len),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .rx_ready    (rx_ready),
        .pc          (pc),
        .inst        (inst),
        .cpu_reset   (cpu_reset),
        .busy        (busy),
        .done        (done),
        .error       (error),
        .words_loaded(words_loaded)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic fetch(input logic [ADDR_W-1:0] a, input logic [31:0] exp, input string tag);
        pc = a;
        tick;
        check(tag, inst, exp);
    endtask

    // Loads the bytes in stim. gap inserts an idle rx_valid=0 cycle before each byte;
    // poke raises an illegal load_start mid-load and a legal one during FLUSH.
    task automatic do_load(input logic [ADDR_W:0] len, input bit gap, input bit poke);
        int t;
        load_start = 1'b1;
        load_len   = len;
        tick;
        load_start = 1'b0;
        check("load_busy", busy, 1);
        check("load_rx_ready", rx_ready, 1);
        check("load_cpu_reset", cpu_reset, 1);
        check("load_inst", inst, 0);
        check("load_error_clr", error, 0);
        check("load_wl_clr", words_loaded, 0);
        for (int i = 0; i < stim.size(); i++) begin
            if (gap) begin
                rx_valid = 1'b0;
                rx_data  = 8'hA5;
                tick;
            end
            if (poke && i == 1) begin
                load_start = 1'b1;
                load_len   = '0;
            end
            rx_valid = 1'b1;
            rx_data  = stim[i];
            t = 0;
            while (!rx_ready && t < 16) begin
                tick;
                t++;
            end
            if (t == 16) check("rx_ready_wait", rx_ready, 1);
            tick;
            load_start = 1'b0;
        end
        rx_valid = 1'b0;
        check("flush_cpu_reset", cpu_reset, 1);
        check("flush_busy", busy, 1);
        check("flush_rx_ready", rx_ready, 0);
        check("flush_wl", words_loaded, len);
        check("flush_done", done, 0);
        check("flush_error", error, 0);
        if (poke) begin
            load_start = 1'b1;
            load_len   = 5'd1;
        end
        tick;
        load_start = 1'b0;
        check("run_cpu_reset", cpu_reset, 0);
        check("run_done", done, 1);
        check("run_busy", busy, 0);
        check("run_inst_first", inst, 0);
        check("run_wl", words_loaded, len);
        tick;
        check("run_done_clr", done, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) tick;
        check("rst_inst", inst, 0);
        check("rst_cpu_reset", cpu_reset, 1);
        check("rst_rx_ready", rx_ready, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_error", error, 0);
        check("rst_wl", words_loaded, 0);
        reset = 1'b1;
        tick;
        check("hold_cpu_reset", cpu_reset, 1);
        check("hold_inst", inst, 0);

        // Back-to-back 3-word load.
        stim = '{8'h00, 8'h02, 8'hEC, 8'h10, 8'h00, 8'h03};
        do_load(5'd3, 1'b0, 1'b0);
        fetch(4'd1, 32'hEC10, "t1_pc1");
        fetch(4'd0, 32'h0002, "t1_pc0");
        fetch(4'd1, 32'hEC10, "t1_pc1b");
        fetch(4'd2, 32'h0003, "t1_pc2");
        fetch(4'd4, 32'h0000, "t1_pc4_nop");
        fetch(4'd5, 32'h0000, "t1_pc5_nop");

        // Illegal lengths while running.
        load_start = 1'b1;
        load_len   = 5'd0;
        tick;
        load_start = 1'b0;
        check("run_err0_error", error, 1);
        check("run_err0_cpu_reset", cpu_reset, 0);
        load_start = 1'b1;
        load_len   = 5'd5;
        tick;
        load_start = 1'b0;
        check("run_err5_error", error, 1);
        check("run_err5_busy", busy, 0);
        fetch(4'd2, 32'h0003, "run_err_fetch");

        // Asynchronous reset pulse from RUN.
        #2 reset = 1'b0;
        #1;
        check("arst_error", error, 0);
        check("arst_cpu_reset", cpu_reset, 1);
        check("arst_inst", inst, 0);
        reset = 1'b1;
        tick;

        // Illegal lengths while held.
        load_start = 1'b1;
        load_len   = 5'd0;
        tick;
        load_start = 1'b0;
        check("hold_err0_error", error, 1);
        check("hold_err0_cpu_reset", cpu_reset, 1);
        check("hold_err0_busy", busy, 0);
        load_start = 1'b1;
        load_len   = 5'd5;
        tick;
        load_start = 1'b0;
        check("hold_err5_error", error, 1);
        check("hold_err5_rx_ready", rx_ready, 0);

        // Reset after 3 of 4 bytes of a 2-word load.
        load_start = 1'b1;
        load_len   = 5'd2;
        tick;
        load_start = 1'b0;
        check("mid_error_clr", error, 0);
        rx_valid = 1'b1;
        rx_data  = 8'h12;
        tick;
        rx_data  = 8'h34;
        tick;
        rx_data  = 8'h56;
        tick;
        rx_valid = 1'b0;
        check("mid_wl", words_loaded, 1);
        #2 reset = 1'b0;
        #1;
        check("mid_inst", inst, 0);
        check("mid_cpu_reset", cpu_reset, 1);
        check("mid_rx_ready", rx_ready, 0);
        check("mid_wl_rst", words_loaded, 0);
        reset = 1'b1;
        tick;
        check("mid_hold_cpu_reset", cpu_reset, 1);
        check("mid_hold_busy", busy, 0);
        stim = '{8'h11, 8'h11, 8'h22, 8'h22};
        do_load(5'd2, 1'b0, 1'b0);
        fetch(4'd0, 32'h1111, "mid_pc0");
        fetch(4'd1, 32'h2222, "mid_pc1");
        fetch(4'd2, 32'h0003, "mid_pc2_kept");

        // Same 3-word program with rx_valid toggling.
        stim = '{8'h00, 8'h02, 8'hEC, 8'h10, 8'h00, 8'h03};
        do_load(5'd3, 1'b1, 1'b0);
        fetch(4'd0, 32'h0002, "gap_pc0");
        fetch(4'd1, 32'hEC10, "gap_pc1");
        fetch(4'd2, 32'h0003, "gap_pc2");

        // Full-depth load with ignored load_start in LOAD and FLUSH.
        stim = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
        do_load(5'd4, 1'b0, 1'b1);
        fetch(4'd0, 32'h0102, "full_pc0");
        fetch(4'd1, 32'h0304, "full_pc1");
        fetch(4'd2, 32'h0506, "full_pc2");
        fetch(4'd3, 32'h0708, "full_pc3");
        fetch(4'd4, 32'h0000, "full_pc4_nop");
        check("full_error", error, 0);

        // Reload one word from RUN.
        stim = '{8'hAB, 8'hCD};
        do_load(5'd1, 1'b0, 1'b0);
        fetch(4'd0, 32'hABCD, "rel_pc0");
        fetch(4'd1, 32'h0304, "rel_pc1_kept");
        fetch(4'd2, 32'h0506, "rel_pc2_kept");
        fetch(4'd3, 32'h0708, "rel_pc3_kept");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/instruction_store.md
# instruction_store

Parametrised, loadable instruction memory with run control for the Hack computer. It replaces a hard-coded program ROM with on-chip storage that is filled from a byte stream at run time. While a program is being loaded, it holds the CPU in reset. Once loading finishes, it serves registered instruction fetches from `pc`.

## Interface
Parameters:
- `DATA_W`, 16: instruction width in bits; must be a multiple of 8.
- `ADDR_W`, 15: fetch/write address width.
- `DEPTH`, 32768: number of stored words; must satisfy `DEPTH` ≤ 2^`ADDR_W`.

Ports:
- `clk`, in, 1: single clock; all state is updated on the rising edge.
- `reset`, in, 1: asynchronous, active-low reset.
- `load_start`, in, 1: one-cycle request to begin a load session.
- `load_len`, in, `ADDR_W`+1: number of words to load; sampled when `load_start` is accepted.
- `rx_data`, in, 8: incoming program byte.
- `rx_valid`, in, 1: `rx_data` is valid.
- `rx_ready`, out, 1: the block accepts a byte when `rx_valid` and `rx_ready` are both high.
- `pc`, in, `ADDR_W`: fetch address from the CPU.
- `inst`, out, `DATA_W`: registered instruction.
- `cpu_reset`, out, 1: active-high reset to the CPU.
- `busy`, out, 1: high in LOAD and FLUSH.
- `done`, out, 1: one-cycle pulse when a load completes.
- `error`, out, 1: sticky; set by a rejected `load_start`.
- `words_loaded`, out, `ADDR_W`+1: number of words written in the current or most recent session.

## Operation
- States are HOLD, LOAD, FLUSH and RUN. Reset enters HOLD.
- Values forced by reset: `inst`=0, `cpu_reset`=1, `rx_ready`=0, `busy`=0, `done`=0, `error`=0, `words_loaded`=0, byte counter 0.
- Reset does not clear memory contents.
- HOLD:
  - `cpu_reset`=1 and `inst`=0.
  - `load_start` with 1 ≤ `load_len` ≤ `DEPTH` goes to LOAD and clears `error` and `words_loaded`.
  - Any other `load_len` sets `error` and stays in HOLD.
- LOAD:
  - `rx_ready`=1 and `cpu_reset`=1.
  - Bytes are big-endian: the first byte of each word is the MSB.
  - A word is complete after `DATA_W`/8 accepted bytes. It is written to address `words_loaded` on the edge that accepts its last byte, and `words_loaded` increments on that same edge.
  - When the write takes `words_loaded` to `load_len`, the next state is FLUSH.
  - `load_start` is ignored while in LOAD.
- FLUSH:
  - Lasts one cycle, with `rx_ready`=0 and `cpu_reset`=1.
  - Moves to RUN; `done` pulses high in the first RUN cycle.
- RUN:
  - `cpu_reset`=0 and `rx_ready`=0.
  - Each cycle, `inst` ← mem[`pc`] if `pc` < `DEPTH`, otherwise 0 (NOP, @0).
  - `load_start` with a legal length goes to LOAD and reasserts `cpu_reset` in the next cycle.
  - A `load_start` with an illegal length sets `error` and stays in RUN.
- `inst` is 0 in every state other than RUN.
- Words at or beyond `load_len` keep their previous contents.
- `rx_valid` while `rx_ready`=0 is ignored; no byte is consumed.

## Timing
- Fetch latency: 1 cycle. A `pc` value presented before edge k appears on `inst` after edge k.
- `cpu_reset` falls on the same edge that enters RUN, which is 2 edges after the last byte is accepted.
- The first valid fetch is mem[`pc`] on the edge after entering RUN. In that first RUN cycle, `inst`=0.
- Minimum duration of an N-word load: N·(`DATA_W`/8) accepting cycles plus 1 FLUSH cycle.
- Back-to-back bytes (`rx_valid` held high) are accepted every cycle with no bubbles.
- Reset asserted mid-LOAD:
  - Outputs take their reset values immediately (asynchronously).
  - Words already written remain in memory; a partial word is discarded.
  - The block stays in HOLD until a new `load_start`.
- `load_start` in FLUSH is ignored.
- `load_len`=`DEPTH` fills the whole memory: `words_loaded` reaches `DEPTH` without wrapping, since it is `ADDR_W`+1 bits wide.

## Test plan
- Reset, then load `load_len`=3 with bytes 00,02,EC,10,00,03 (back-to-back):
  - mem[0..2] = 0002, EC10, 0003.
  - `words_loaded`=3, `done` pulses once.
  - `cpu_reset` falls 2 cycles after the last byte.
  - With `pc`=1, `inst`=EC10 one cycle later.
- Same load with `rx_valid` toggling every other cycle: identical memory contents, and no byte is lost or duplicated.
- `load_start` with `load_len`=0, then with `load_len`=`DEPTH`+1:
  - `error`=1, state unchanged, `cpu_reset` stays 1 in HOLD.
  - A following legal load clears `error`.
- Reset pulsed after 3 of 4 bytes of a 2-word load:
  - mem[0] holds the new word; `inst`=0 and `cpu_reset`=1.
  - A reload of 2 words then runs normally.
- In RUN with `pc` sweeping 0..4 after a 3-word load: `inst` follows mem with 1-cycle lag. With `DEPTH`=4 and `pc`=5, `inst`=0.
- Reload from RUN with `load_len`=1 and bytes AB,CD:
  - `cpu_reset` rises the next cycle, and `inst`=0 during LOAD.
  - mem[0]=ABCD; mem[1..2] are unchanged from the previous program.
